// File: rtl/flag_register_unit_pkg.sv
// Shared encodings for the flag register unit: ALU opcodes, flag bit
// positions and the per-op flag update masks.
package flag_register_unit_pkg;

   localparam logic [2:0] ALU_ADD = 3'b000;
   localparam logic [2:0] ALU_SUB = 3'b001;
   localparam logic [2:0] ALU_AND = 3'b010;
   localparam logic [2:0] ALU_ORR = 3'b011;

   localparam int N_IDX = 3;
   localparam int Z_IDX = 2;
   localparam int C_IDX = 1;
   localparam int V_IDX = 0;

   localparam logic [3:0] MASK_LOGIC = 4'b1100;
   localparam logic [3:0] MASK_ARITH = 4'b1111;

   typedef struct packed {
      logic [3:0] raw;
      logic [3:0] mask;
   } flag_upd_t;

endpackage

// File: rtl/flag_register_unit_flag_generator.sv
// Combinational NZCV generator: raw flags and write mask for one ALU op.
module flag_generator
   import flag_register_unit_pkg::*;
#(
   parameter int WIDTH = 32
) (
   input  logic [WIDTH-1:0] SrcA,
   input  logic [WIDTH-1:0] SrcB,
   input  logic [WIDTH-1:0] ALUResult,
   input  logic [2:0]       ALUControl,
   output logic [3:0]       raw,
   output logic [3:0]       mask
);

   logic carry_add;
   logic carry_sub;
   logic a_msb, b_msb, r_msb;

   // Carry-outs without a wide adder: A+B overflows WIDTH bits iff B > ~A,
   // and A+~B+1 carries out iff A >= B (no borrow).
   assign carry_add = (SrcB > ~SrcA);
   assign carry_sub = (SrcA >= SrcB);

   assign a_msb = SrcA[WIDTH-1];
   assign b_msb = SrcB[WIDTH-1];
   assign r_msb = ALUResult[WIDTH-1];

   always_comb begin
      raw        = 4'b0000;
      mask       = MASK_LOGIC;
      raw[N_IDX] = r_msb;
      raw[Z_IDX] = (ALUResult == '0);
      case (ALUControl)
         ALU_ADD: begin
            mask       = MASK_ARITH;
            raw[C_IDX] = carry_add;
            raw[V_IDX] = (a_msb == b_msb) && (r_msb != a_msb);
         end
         ALU_SUB: begin
            mask       = MASK_ARITH;
            raw[C_IDX] = carry_sub;
            raw[V_IDX] = (a_msb != b_msb) && (r_msb != a_msb);
         end
         default: begin
            mask = MASK_LOGIC;
         end
      endcase
   end

endmodule

// File: rtl/flag_register_unit.sv
// Two-stage NZCV flag register: capture raw flags, then commit under mask.
// Optional FLAG_BYPASS_EN forwards the in-flight update onto Flags.
module flag_register_unit
   import flag_register_unit_pkg::*;
#(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] SrcA,
   input  logic [WIDTH-1:0] SrcB,
   input  logic [WIDTH-1:0] ALUResult,
   input  logic [2:0]       ALUControl,
   input  logic             FlagWrite,
   input  logic             CondEx,
   input  logic             Stall,
   input  logic             Flush,
   output logic [3:0]       Flags,
   output logic             FlagsPending
);

   flag_upd_t  gen_upd;
   flag_upd_t  upd_p1_d, upd_p1_q;
   logic       vld_p1_d, vld_p1_q;
   logic [3:0] arch_d, arch_q;
   logic [3:0] merged;
   logic       capture;

   flag_generator #(.WIDTH(WIDTH)) u_gen (
      .SrcA       (SrcA),
      .SrcB       (SrcB),
      .ALUResult  (ALUResult),
      .ALUControl (ALUControl),
      .raw        (gen_upd.raw),
      .mask       (gen_upd.mask)
   );

   assign capture = FlagWrite && CondEx && !Stall && !Flush;
   assign merged  = (arch_q & ~upd_p1_q.mask) | (upd_p1_q.raw & upd_p1_q.mask);

   always_comb begin
      arch_d   = arch_q;
      upd_p1_d = upd_p1_q;
      vld_p1_d = vld_p1_q;
      if (!Stall) begin
         // Stage 2: commit the update captured on the previous edge.
         if (vld_p1_q) begin
            arch_d = merged;
         end
         // Stage 1: capture the next update alongside the commit.
         vld_p1_d = capture;
         if (capture) begin
            upd_p1_d = gen_upd;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         arch_q   <= 4'b0000;
         upd_p1_q <= '0;
         vld_p1_q <= 1'b0;
      end else begin
         arch_q   <= arch_d;
         upd_p1_q <= upd_p1_d;
         vld_p1_q <= vld_p1_d;
      end
   end

`ifdef FLAG_BYPASS_EN
   assign Flags = vld_p1_q ? merged : arch_q;
`else
   assign Flags = arch_q;
`endif

   assign FlagsPending = vld_p1_q;

endmodule

// File: tb/tb_flag_register_unit.sv
// Self-checking bench for flag_register_unit: directed scenarios then random
// traffic, each cycle compared against an arithmetic reference model.
module tb_flag_register_unit;

   localparam int WIDTH = 32;

   logic             clk = 1'b0;
   logic             rst;
   logic [WIDTH-1:0] SrcA, SrcB, ALUResult;
   logic [2:0]       ALUControl;
   logic             FlagWrite, CondEx, Stall, Flush;
   logic [3:0]       Flags;
   logic             FlagsPending;

   int checks   = 0;
   int failures = 0;

   logic [3:0] m_arch, m_raw, m_mask;
   logic       m_pend;

   flag_register_unit #(.WIDTH(WIDTH)) dut (
      .clk          (clk),
      .rst          (rst),
      .SrcA         (SrcA),
      .SrcB         (SrcB),
      .ALUResult    (ALUResult),
      .ALUControl   (ALUControl),
      .FlagWrite    (FlagWrite),
      .CondEx       (CondEx),
      .Stall        (Stall),
      .Flush        (Flush),
      .Flags        (Flags),
      .FlagsPending (FlagsPending)
   );

   always #5 clk = ~clk;

   // Reference flags from plain integer arithmetic on the operands.
   function automatic logic [7:0] ref_update(input logic [2:0] op,
                                              input logic [31:0] a,
                                              input logic [31:0] b,
                                              input logic [31:0] res);
      longint ua, ub, sa, sb, s;
      logic n, z, c, v;
      ua = longint'({32'h0, a});
      ub = longint'({32'h0, b});
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      n  = res[31];
      z  = (res == 32'h0);
      c  = 1'b0;
      v  = 1'b0;
      if (op == 3'b000) begin
         c = (ua + ub) >= 64'sh1_0000_0000;
         s = sa + sb;
         v = (s > 64'sh7FFF_FFFF) || (s < -64'sh8000_0000);
         return {n, z, c, v, 4'b1111};
      end else if (op == 3'b001) begin
         c = (ua >= ub);
         s = sa - sb;
         v = (s > 64'sh7FFF_FFFF) || (s < -64'sh8000_0000);
         return {n, z, c, v, 4'b1111};
      end
      return {n, z, c, v, 4'b1100};
   endfunction

   function automatic logic [31:0] alu(input logic [2:0] op,
                                       input logic [31:0] a,
                                       input logic [31:0] b);
      case (op)
         3'b000:  return a + b;
         3'b001:  return a - b;
         3'b010:  return a & b;
         3'b011:  return a | b;
         default: return a ^ b;
      endcase
   endfunction

   function automatic logic [3:0] model_flags();
`ifdef FLAG_BYPASS_EN
      if (m_pend) return (m_arch & ~m_mask) | (m_raw & m_mask);
`endif
      return m_arch;
   endfunction

   task automatic check(input string tag, input logic [3:0] got, input logic [3:0] exp);
      checks++;
      assert (got === exp)
      else begin
         failures++;
         $error("FAIL %s got=%b exp=%b", tag, got, exp);
      end
   endtask

   // One clock: drive inputs, advance model on the edge, compare after it.
   task automatic step(input logic r, input logic fw, input logic ce,
                       input logic st, input logic fl, input logic [2:0] op,
                       input logic [31:0] a, input logic [31:0] b);
      logic [7:0] upd;
      logic [31:0] res;
      res = alu(op, a, b);
      rst = r; FlagWrite = fw; CondEx = ce; Stall = st; Flush = fl;
      ALUControl = op; SrcA = a; SrcB = b; ALUResult = res;
      @(posedge clk);
      upd = ref_update(op, a, b, res);
      if (r) begin
         m_arch = 4'b0; m_raw = 4'b0; m_mask = 4'b0; m_pend = 1'b0;
      end else if (!st) begin
         if (m_pend) m_arch = (m_arch & ~m_mask) | (m_raw & m_mask);
         m_pend = fw && ce && !fl;
         if (m_pend) begin
            m_raw  = upd[7:4];
            m_mask = upd[3:0];
         end
      end
      #1;
      check("flags_model", Flags, model_flags());
      check("pending_model", {3'b0, FlagsPending}, {3'b0, m_pend});
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'b000, 32'h0, 32'h0);
   endtask

   initial begin
      logic [31:0] ra, rb;
      logic [2:0]  rop;
      m_arch = 4'b0; m_raw = 4'b0; m_mask = 4'b0; m_pend = 1'b0;

      step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 3'b000, 32'h0, 32'h0);
      step(1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 3'b001, 32'h5, 32'h9);
      idle(1);
      check("reset_flags", Flags, 4'b0000);
      check("reset_pending", {3'b0, FlagsPending}, 4'b0000);

      // SUB 5-5 -> Z and C set
      step(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 3'b001, 32'd5, 32'd5);
      check("sub55_pending", {3'b0, FlagsPending}, 4'b0001);
      idle(1);
      check("sub55_flags", Flags, 4'b0110);
      check("sub55_pending_clear", {3'b0, FlagsPending}, 4'b0000);

      // ADD overflow then ORR zero back-to-back: C,V preserved
      step(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 3'b000, 32'h7FFF_FFFF, 32'h1);
      step(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 3'b011, 32'h0, 32'h0);
      check("add_ovf_flags", Flags, `ifdef FLAG_BYPASS_EN 4'b0101 `else 4'b1001 `endif);
      idle(1);
      check("orr_preserve", Flags, 4'b0101);

      // SUB 3-5 with a 3-cycle stall on the commit cycle
      step(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 3'b001, 32'd3, 32'd5);
      for (int i = 0; i < 3; i++) begin
         step(1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 3'b000, 32'h0, 32'h0);
         check("stall_hold", Flags, `ifdef FLAG_BYPASS_EN 4'b1000 `else 4'b0101 `endif);
         check("stall_pending", {3'b0, FlagsPending}, 4'b0001);
      end
      idle(1);
      check("stall_commit", Flags, 4'b1000);

      // Flushed capture of ADD 0xFFFFFFFF+1
      step(1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 3'b000, 32'hFFFF_FFFF, 32'h1);
      check("flush_pending", {3'b0, FlagsPending}, 4'b0000);
      idle(2);
      check("flush_flags", Flags, 4'b1000);

      // CondEx=0 captures nothing
      step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 3'b001, 32'h0, 32'h0);
      idle(3);
      check("condex0_flags", Flags, 4'b1000);

      // Reset while pending kills the commit
      step(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 3'b000, 32'hFFFF_FFFF, 32'h1);
      step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 3'b000, 32'h0, 32'h0);
      check("rst_pend_flags", Flags, 4'b0000);
      check("rst_pend_pending", {3'b0, FlagsPending}, 4'b0000);
      idle(2);
      check("rst_no_stale", Flags, 4'b0000);

      for (int i = 0; i < 400; i++) begin
         rop = 3'($urandom_range(0, 7));
         if (rop > 3'd4 && $urandom_range(0, 1) == 0) rop = 3'($urandom_range(0, 1));
         case ($urandom_range(0, 5))
            0: ra = 32'h7FFF_FFFF;
            1: ra = 32'h8000_0000;
            2: ra = 32'hFFFF_FFFF;
            default: ra = $urandom;
         endcase
         case ($urandom_range(0, 5))
            0: rb = 32'h1;
            1: rb = ra;
            2: rb = 32'h0;
            default: rb = $urandom;
         endcase
         step($urandom_range(0, 49) == 0, $urandom_range(0, 4) != 0,
              $urandom_range(0, 4) != 0, $urandom_range(0, 4) == 0,
              $urandom_range(0, 9) == 0, rop, ra, rb);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
